wb_stage_regfile: RTL and testbench

- Write-back end of the 4-stage pipeline: owns the MEM/WB pipeline register and the 16x32 architectural register file.
- Broadcasts the WB bus (opcode, index, data) consumed by the writeback forwarding units in the decode/execute paths.
- Performs the register-file write.
- Provides two combinational read ports with same-cycle write-through, plus a retired-instruction counter.

---
 rtl/wb_stage_regfile_pkg.sv | 19 +
 rtl/wb_stage_regfile_regfile_2r1w.sv | 42 ++++
 rtl/wb_stage_regfile.sv | 86 ++++++++
 tb/tb_wb_stage_regfile.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_regfile_pkg.sv
// Shared definitions for the write-back stage and the forwarding units:
// opcode encodings, default widths and the register-write qualifier.
package wb_stage_regfile_pkg;

    localparam int OPCODE_W      = 4;
    localparam int DEF_INDEX_W   = 4;
    localparam int DEF_DATA_W    = 32;
    localparam int RETIRED_W     = 32;

    localparam logic [OPCODE_W-1:0] OP_NOP    = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_SW     = 4'b0011;

    // Branches and stores occupy WB but never produce a register result.
    function automatic logic writes_regfile(input logic valid, input logic [OPCODE_W-1:0] opcode);
        return valid && (opcode != OP_BRANCH) && (opcode != OP_SW);
    endfunction

endpackage

// File: rtl/wb_stage_regfile_regfile_2r1w.sv
// Architectural register file: one synchronous write port, two
// asynchronous read ports, synchronous clear of every entry on reset.
module regfile_2r1w
    import wb_stage_regfile_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [INDEX_W-1:0] rd_index_a,
    input  logic [INDEX_W-1:0] rd_index_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b
);

    localparam int DEPTH = 2 ** INDEX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage update: clear everything on reset, otherwise perform the write.
    // NOTE: every entry is reset because software may read any register
    // before writing it; this forces flops rather than a RAM macro.
    // NOTE: non-blocking assignments keep all state updates on this edge
    // ordered independently of other always_ff blocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_index] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_index_a];
    assign rd_data_b = mem[rd_index_b];

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: MEM/WB pipeline register, WB broadcast bus, register
// file write, bypassed read ports and the retired-instruction counter.
module wb_stage_regfile
    import wb_stage_regfile_pkg::*;
#(
    parameter int REG_INDEX_BIT_WIDTH = DEF_INDEX_W,
    parameter int bitwidth            = DEF_DATA_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           mem_valid,
    input  logic [OPCODE_W-1:0]            mem_opcode,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] mem_index,
    input  logic [bitwidth-1:0]            mem_data,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index_a,
    input  logic [REG_INDEX_BIT_WIDTH-1:0] rd_index_b,
    output logic [bitwidth-1:0]            rd_data_a,
    output logic [bitwidth-1:0]            rd_data_b,
    output logic                           WB_valid,
    output logic [OPCODE_W-1:0]            WB_opcode,
    output logic [REG_INDEX_BIT_WIDTH-1:0] WB_index,
    output logic [bitwidth-1:0]            WB_data,
    output logic                           WB_we,
    output logic [RETIRED_W-1:0]           retired_count
);

    logic [bitwidth-1:0] array_data_a;
    logic [bitwidth-1:0] array_data_b;

    assign WB_we = writes_regfile(WB_valid, WB_opcode);

    // MEM/WB register: reset > flush (bubble) > stall (hold) > load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            WB_valid  <= 1'b0;
            WB_opcode <= OP_NOP;
            WB_index  <= '0;
            WB_data   <= '0;
        end else if (!stall) begin
            WB_valid  <= mem_valid;
            WB_opcode <= mem_opcode;
            WB_index  <= mem_index;
            WB_data   <= mem_data;
        end
    end

    // Count an instruction when it leaves WB; a flush still retires the occupant.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_count <= '0;
        end else if (WB_valid && !stall) begin
            retired_count <= retired_count + 1'b1;
        end
    end

    regfile_2r1w #(
        .INDEX_W (REG_INDEX_BIT_WIDTH),
        .DATA_W  (bitwidth)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we         (WB_we),
        .wr_index   (WB_index),
        .wr_data    (WB_data),
        .rd_index_a (rd_index_a),
        .rd_index_b (rd_index_b),
        .rd_data_a  (array_data_a),
        .rd_data_b  (array_data_b)
    );

    // Write-through: a read of the register being written this cycle sees WB_data.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        rd_data_a = array_data_a;
        rd_data_b = array_data_b;
        if (WB_we && (rd_index_a == WB_index)) begin
            rd_data_a = WB_data;
        end
        if (WB_we && (rd_index_b == WB_index)) begin
            rd_data_b = WB_data;
        end
    end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed self-checking bench for wb_stage_regfile.
module tb_wb_stage_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [3:0]  mem_index;
    logic [31:0] mem_data;
    logic [3:0]  rd_index_a;
    logic [3:0]  rd_index_b;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        WB_valid;
    logic [3:0]  WB_opcode;
    logic [3:0]  WB_index;
    logic [31:0] WB_data;
    logic        WB_we;
    logic [31:0] retired_count;

    int n_cmp = 0;
    int n_err = 0;

    wb_stage_regfile dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .mem_valid     (mem_valid),
        .mem_opcode    (mem_opcode),
        .mem_index     (mem_index),
        .mem_data      (mem_data),
        .rd_index_a    (rd_index_a),
        .rd_index_b    (rd_index_b),
        .rd_data_a     (rd_data_a),
        .rd_data_b     (rd_data_b),
        .WB_valid      (WB_valid),
        .WB_opcode     (WB_opcode),
        .WB_index      (WB_index),
        .WB_data       (WB_data),
        .WB_we         (WB_we),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_mem(input logic v, input logic [3:0] op, input logic [3:0] idx, input logic [31:0] d);
        mem_valid  = v;
        mem_opcode = op;
        mem_index  = idx;
        mem_data   = d;
    endtask

    task automatic read_ab(input logic [3:0] a, input logic [3:0] b);
        rd_index_a = a;
        rd_index_b = b;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        rd_index_a = '0;
        rd_index_b = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state: every register reads zero, WB empty, counter zero.
        for (int i = 0; i < 16; i++) begin
            read_ab(4'(i), 4'(15 - i));
            check($sformatf("reset_rd_a[%0d]", i), rd_data_a, 32'h0);
            check($sformatf("reset_rd_b[%0d]", 15 - i), rd_data_b, 32'h0);
        end
        check("reset_wb_valid", WB_valid, 1'b0);
        check("reset_wb_we", WB_we, 1'b0);
        check("reset_retired", retired_count, 32'd0);

        // ADD to r5: visible by bypass in WB, then from the array.
        drive_mem(1'b1, 4'b0001, 4'd5, 32'hDEADBEEF);
        step();
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        read_ab(4'd5, 4'd5);
        check("add_wb_index", WB_index, 4'd5);
        check("add_wb_we", WB_we, 1'b1);
        check("add_bypass_a", rd_data_a, 32'hDEADBEEF);
        check("add_bypass_b_same_reg", rd_data_b, 32'hDEADBEEF);
        check("add_retired_in_wb", retired_count, 32'd0);
        step();
        check("add_array_a", rd_data_a, 32'hDEADBEEF);
        check("add_after_we", WB_we, 1'b0);
        check("add_retired", retired_count, 32'd1);

        // BRANCH then SW to r3: neither writes, both retire.
        drive_mem(1'b1, 4'b0010, 4'd3, 32'h11);
        read_ab(4'd3, 4'd5);
        step();
        check("branch_we", WB_we, 1'b0);
        check("branch_rd_a", rd_data_a, 32'h0);
        drive_mem(1'b1, 4'b0011, 4'd3, 32'h22);
        step();
        check("sw_we", WB_we, 1'b0);
        check("sw_wb_data", WB_data, 32'h22);
        check("sw_rd_a", rd_data_a, 32'h0);
        check("sw_retired", retired_count, 32'd2);
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        step();
        check("br_sw_reg3", rd_data_a, 32'h0);
        check("br_sw_retired", retired_count, 32'd3);

        // r7 load held by a 3-cycle stall while MEM presents something else.
        drive_mem(1'b1, 4'b0001, 4'd7, 32'hA5A5A5A5);
        step();
        check("stall_pre_retired", retired_count, 32'd3);
        stall = 1'b1;
        drive_mem(1'b1, 4'b0001, 4'd9, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall_wb_index[%0d]", c), WB_index, 4'd7);
            check($sformatf("stall_wb_data[%0d]", c), WB_data, 32'hA5A5A5A5);
            check($sformatf("stall_wb_valid[%0d]", c), WB_valid, 1'b1);
            check($sformatf("stall_retired[%0d]", c), retired_count, 32'd3);
        end
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        stall = 1'b0;
        step();
        read_ab(4'd5, 4'd7);
        check("stall_release_retired", retired_count, 32'd4);
        check("stall_release_valid", WB_valid, 1'b0);
        check("stall_reg7", rd_data_b, 32'hA5A5A5A5);

        // stall+flush together: flush wins, departing instruction not counted.
        drive_mem(1'b1, 4'b0001, 4'd8, 32'h80);
        step();
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        read_ab(4'd8, 4'd8);
        check("sf_wb_valid", WB_valid, 1'b0);
        check("sf_wb_index", WB_index, 4'd0);
        check("sf_wb_data", WB_data, 32'h0);
        check("sf_retired", retired_count, 32'd4);
        check("sf_reg8_written", rd_data_a, 32'h80);

        // flush alone: departing instruction is counted.
        drive_mem(1'b1, 4'b0001, 4'd9, 32'h99);
        step();
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_wb_valid", WB_valid, 1'b0);
        check("flush_retired", retired_count, 32'd5);

        // Back-to-back writes to r4: later one wins.
        drive_mem(1'b1, 4'b0001, 4'd4, 32'h1);
        read_ab(4'd4, 4'd4);
        step();
        check("b2b_first", rd_data_a, 32'h1);
        drive_mem(1'b1, 4'b0001, 4'd4, 32'h2);
        step();
        check("b2b_second_bypass", rd_data_b, 32'h2);
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        step();
        check("b2b_array", rd_data_a, 32'h2);
        check("b2b_retired", retired_count, 32'd7);

        // Reset mid-stall with r2 write pending: write dropped, all cleared.
        drive_mem(1'b1, 4'b0001, 4'd2, 32'h55);
        step();
        drive_mem(1'b0, 4'h0, 4'h0, 32'h0);
        check("rst_pending_we", WB_we, 1'b1);
        stall = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        stall = 1'b0;
        read_ab(4'd2, 4'd7);
        check("rst_reg2", rd_data_a, 32'h0);
        check("rst_reg7", rd_data_b, 32'h0);
        check("rst_wb_valid", WB_valid, 1'b0);
        check("rst_wb_opcode", WB_opcode, 4'h0);
        check("rst_wb_index", WB_index, 4'h0);
        check("rst_wb_data", WB_data, 32'h0);
        check("rst_retired", retired_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
